// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array scheduler: base codes, channel
// states and a bit-width helper.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'b10;
  localparam logic [1:0] BASE_G = 2'b11;
  localparam logic [1:0] BASE_T = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;

  // Score bias; a timed-out run reports this value.
  localparam int unsigned ZERO = 0;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_STREAM = 2'd1,
    CH_DRAIN  = 2'd2,
    CH_DONE   = 2'd3
  } ch_state_t;

  // Bits needed to index v values (minimum 1).
  function automatic int unsigned log2b(input int unsigned v);
    int unsigned r = 1;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sw_array_scheduler_if.sv
// Per-channel start / base-stream / result handshake bundle for both channels.
interface sw_array_scheduler_if #(
  parameter int unsigned TLEN_WIDTH  = 16,
  parameter int unsigned SCORE_WIDTH = 12
);
  logic [1:0]               s_start;
  logic [2*TLEN_WIDTH-1:0]  s_tlen;
  logic [1:0]               s_idle;
  logic [3:0]               s_base;
  logic [1:0]               s_base_valid;
  logic [1:0]               s_base_ready;
  logic [1:0]               s_done_valid;
  logic [1:0]               s_done_ready;
  logic [2*SCORE_WIDTH-1:0] s_score;
  logic [1:0]               s_timeout;

  modport master (
    output s_start, s_tlen, s_base, s_base_valid, s_done_ready,
    input  s_idle, s_base_ready, s_done_valid, s_score, s_timeout
  );

  modport slave (
    input  s_start, s_tlen, s_base, s_base_valid, s_done_ready,
    output s_idle, s_base_ready, s_done_valid, s_score, s_timeout
  );
endinterface

// File: rtl/sw_channel_fsm.sv
// One target-sequence channel: streams bases into its toggle slot, waits for the
// array's valid (or times out) and holds the score until the consumer takes it.
module sw_channel_fsm
  import sw_pkg::*;
#(
  parameter int unsigned CH          = 0,
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned TLEN_WIDTH  = 16,
  parameter int unsigned DRAIN_MAX   = 272
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TLEN_WIDTH-1:0]  tlen_in,
  input  logic                   load_accept,
  input  logic                   arr_toggle,
  input  logic                   base_valid,
  output logic                   base_ready_c,
  output logic                   xfer_c,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  output logic                   idle,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   timeout
);

  localparam int unsigned DCNT_W = log2b(DRAIN_MAX);

  ch_state_t              state, state_nxt;
  logic [TLEN_WIDTH-1:0]  tlen, tlen_nxt;
  logic [TLEN_WIDTH-1:0]  bcnt, bcnt_nxt;
  logic [DCNT_W-1:0]      dcnt, dcnt_nxt;
  logic [SCORE_WIDTH-1:0] score_nxt;
  logic                   timeout_nxt;

  assign base_ready_c = (state == CH_STREAM) && (arr_toggle == 1'(CH));
  assign xfer_c       = base_ready_c && base_valid;
  assign idle         = (state == CH_IDLE);
  assign done_valid   = (state == CH_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CH_IDLE;
      tlen    <= '0;
      bcnt    <= '0;
      dcnt    <= '0;
      score   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      tlen    <= tlen_nxt;
      bcnt    <= bcnt_nxt;
      dcnt    <= dcnt_nxt;
      score   <= score_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tlen_nxt    = tlen;
    bcnt_nxt    = bcnt;
    dcnt_nxt    = dcnt;
    score_nxt   = score;
    timeout_nxt = timeout;
    unique case (state)
      CH_IDLE: begin
        // A query load in the same cycle wins; the start must be retried.
        if (start && (tlen_in != '0) && !load_accept) begin
          tlen_nxt  = tlen_in;
          bcnt_nxt  = '0;
          state_nxt = CH_STREAM;
        end
      end
      CH_STREAM: begin
        if (xfer_c) begin
          bcnt_nxt = bcnt + TLEN_WIDTH'(1);
          if (bcnt_nxt == tlen) begin
            dcnt_nxt  = '0;
            state_nxt = CH_DRAIN;
          end
        end
      end
      CH_DRAIN: begin
        if (arr_vld) begin
          score_nxt   = arr_result;
          timeout_nxt = 1'b0;
          state_nxt   = CH_DONE;
        end else if (dcnt == DCNT_W'(DRAIN_MAX - 1)) begin
          score_nxt   = SCORE_WIDTH'(ZERO);
          timeout_nxt = 1'b1;
          state_nxt   = CH_DONE;
        end else begin
          dcnt_nxt = dcnt + DCNT_W'(1);
        end
      end
      CH_DONE: begin
        if (done_ready) state_nxt = CH_IDLE;
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

endmodule

// File: rtl/sw_array_scheduler.sv
// Front-end controller for the Smith-Waterman array: owns the query registers and
// interleaves two target channels into the array's even/odd toggle slots.
module sw_array_scheduler
  import sw_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned LENGTH      = 128,
  parameter int unsigned ADDR_WIDTH  = log2b(LENGTH),
  parameter int unsigned TLEN_WIDTH  = 16,
  parameter int unsigned DRAIN_MAX   = 2 * LENGTH + 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*LENGTH-1:0]      query_in,
  input  logic [ADDR_WIDTH-1:0]    query_len_in,
  input  logic                     query_load,
  output logic                     query_ok,
  output logic [2*LENGTH-1:0]      query,
  output logic [ADDR_WIDTH-1:0]    output_select,
  sw_array_scheduler_if.slave      sif,
  input  logic                     arr_toggle,
  input  logic [1:0]               arr_vld,
  input  logic [2*SCORE_WIDTH-1:0] arr_result,
  output logic                     en0,
  output logic                     en1,
  output logic [1:0]               data_in
);

  logic                   idle0, idle1;
  logic                   ready0_c, ready1_c;
  logic                   xfer0_c, xfer1_c;
  logic                   done0, done1;
  logic [SCORE_WIDTH-1:0] score0, score1;
  logic                   timeout0, timeout1;
  logic                   load_accept_c;

  // The query may only change while no channel is using the array.
  assign load_accept_c = query_load && idle0 && idle1 && (query_len_in != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      query         <= '0;
      output_select <= ADDR_WIDTH'(1);
      query_ok      <= 1'b0;
    end else begin
      query_ok <= load_accept_c;
      if (load_accept_c) begin
        query         <= query_in;
        output_select <= query_len_in;
      end
    end
  end

  // Slots are disjoint, so at most one channel transfers per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en0     <= 1'b0;
      en1     <= 1'b0;
      data_in <= '0;
    end else begin
      en0 <= xfer0_c;
      en1 <= xfer1_c;
      if (xfer0_c)      data_in <= sif.s_base[1:0];
      else if (xfer1_c) data_in <= sif.s_base[3:2];
    end
  end

  sw_channel_fsm #(
    .CH(0), .SCORE_WIDTH(SCORE_WIDTH), .TLEN_WIDTH(TLEN_WIDTH), .DRAIN_MAX(DRAIN_MAX)
  ) u_ch0 (
    .clk          (clk),
    .rst          (rst),
    .start        (sif.s_start[0]),
    .tlen_in      (sif.s_tlen[TLEN_WIDTH-1:0]),
    .load_accept  (load_accept_c),
    .arr_toggle   (arr_toggle),
    .base_valid   (sif.s_base_valid[0]),
    .base_ready_c (ready0_c),
    .xfer_c       (xfer0_c),
    .arr_vld      (arr_vld[0]),
    .arr_result   (arr_result[SCORE_WIDTH-1:0]),
    .idle         (idle0),
    .done_valid   (done0),
    .done_ready   (sif.s_done_ready[0]),
    .score        (score0),
    .timeout      (timeout0)
  );

  sw_channel_fsm #(
    .CH(1), .SCORE_WIDTH(SCORE_WIDTH), .TLEN_WIDTH(TLEN_WIDTH), .DRAIN_MAX(DRAIN_MAX)
  ) u_ch1 (
    .clk          (clk),
    .rst          (rst),
    .start        (sif.s_start[1]),
    .tlen_in      (sif.s_tlen[2*TLEN_WIDTH-1:TLEN_WIDTH]),
    .load_accept  (load_accept_c),
    .arr_toggle   (arr_toggle),
    .base_valid   (sif.s_base_valid[1]),
    .base_ready_c (ready1_c),
    .xfer_c       (xfer1_c),
    .arr_vld      (arr_vld[1]),
    .arr_result   (arr_result[2*SCORE_WIDTH-1:SCORE_WIDTH]),
    .idle         (idle1),
    .done_valid   (done1),
    .done_ready   (sif.s_done_ready[1]),
    .score        (score1),
    .timeout      (timeout1)
  );

  assign sif.s_idle       = {idle1, idle0};
  assign sif.s_base_ready = {ready1_c, ready0_c};
  assign sif.s_done_valid = {done1, done0};
  assign sif.s_score      = {score1, score0};
  assign sif.s_timeout    = {timeout1, timeout0};

endmodule
